fifo_stream_reader: RTL and testbench

Read-side drain engine for the dual-clock FIFO: runs entirely in the FIFO read clock domain, issues `rd_en` pulses against the FIFO's registered read port, and presents the words as a valid/ready stream with frame markers. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so a downstream consumer sustains one word per cycle and can apply backpressure without losing data.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/skid_buf2.sv | 73 +++++++
 rtl/fifo_stream_reader.sv | 130 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO read-side drain engine.
// Optional statistics outputs are enabled by defining FIFO_READER_STATS_EN.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

    localparam int STATS_W    = 32;
    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/skid_buf2.sv
// Two-entry push/pop buffer that absorbs the FIFO read latency.
// The head register drives the stream data directly.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [DATA_WIDTH-1:0] head_s;
    logic [DATA_WIDTH-1:0] tail_s;
    logic [CNT_W-1:0]      count_s;

    // Next buffer contents from the push/pop pair.
    always_comb begin
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        case ({push, pop})
            2'b10: begin
                count_s = count_r + CNT_W'(1);
                if (count_r == CNT_W'(0)) begin
                    head_s = push_data;
                end else begin
                    tail_s = push_data;
                end
            end
            2'b01: begin
                count_s = count_r - CNT_W'(1);
                head_s  = tail_r;
            end
            2'b11: begin
                // Simultaneous push and pop keeps occupancy; order is preserved via the tail.
                if (count_r == CNT_W'(2)) begin
                    head_s = tail_r;
                    tail_s = push_data;
                end else begin
                    head_s = push_data;
                end
            end
            default: begin
                count_s = count_r;
            end
        endcase
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {DATA_WIDTH{1'b0}};
            tail_r  <= {DATA_WIDTH{1'b0}};
            count_r <= CNT_W'(0);
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            count_r <= count_s;
        end
    end

    assign head_data = head_r;
    assign count     = count_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-clock-domain drain engine: issues FIFO reads and presents a framed valid/ready stream.
// Define FIFO_READER_STATS_EN to add the words_o / stall_o counters.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  rd_clk_i,
    input  logic                  rd_rst_i,
    input  logic                  en_i,
    output logic                  rd_en_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  empty_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [STATS_W-1:0]    words_o,
    output logic [STATS_W-1:0]    stall_o
`endif
);

    localparam int FIDX_W = $clog2(FRAME_LEN);

    reader_state_e         state_r;
    reader_state_e         state_s;
    logic                  inflight_r;
    logic [FIDX_W-1:0]     fidx_r;
    logic [CNT_W-1:0]      count_s;
    logic [CNT_W:0]        occ_s;
    logic                  rd_en_s;
    logic                  pop_s;
    logic                  valid_s;

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (rd_clk_i),
        .rst       (rd_rst_i),
        .push      (inflight_r),
        .pop       (pop_s),
        .push_data (rd_data_i),
        .head_data (m_data_o),
        .count     (count_s)
    );

    assign valid_s = (count_s != CNT_W'(0));
    assign pop_s   = valid_s && m_ready_i;

    // Read issue: occupancy after this cycle must leave room for the word we request.
    always_comb begin
        occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        rd_en_s = 1'b0;
        if (en_i && !empty_i && (state_r == RUN) && (occ_s < (CNT_W + 1)'(SKID_DEPTH))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Next-state logic for IDLE/RUN/DRAIN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_i) state_s = RUN;
                else      state_s = IDLE;
            end
            RUN: begin
                if (!en_i) state_s = DRAIN;
                else       state_s = RUN;
            end
            DRAIN: begin
                if (en_i)                                        state_s = RUN;
                else if ((count_s == CNT_W'(0)) && !inflight_r)  state_s = IDLE;
                else                                             state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, in-flight tracking and frame position.
    always_ff @(posedge rd_clk_i) begin
        if (rd_rst_i) begin
            state_r    <= IDLE;
            inflight_r <= 1'b0;
            fidx_r     <= FIDX_W'(0);
        end else begin
            state_r    <= state_s;
            inflight_r <= rd_en_s;
            if (pop_s) begin
                if (fidx_r == FIDX_W'(FRAME_LEN - 1)) fidx_r <= FIDX_W'(0);
                else                                  fidx_r <= fidx_r + FIDX_W'(1);
            end else begin
                fidx_r <= fidx_r;
            end
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [STATS_W-1:0] words_r;
    logic [STATS_W-1:0] stall_r;

    // Delivered-word and backpressure-cycle counters, wrapping naturally.
    always_ff @(posedge rd_clk_i) begin
        if (rd_rst_i) begin
            words_r <= STATS_W'(0);
            stall_r <= STATS_W'(0);
        end else begin
            if (pop_s) words_r <= words_r + STATS_W'(1);
            else       words_r <= words_r;
            if (valid_s && !m_ready_i) stall_r <= stall_r + STATS_W'(1);
            else                       stall_r <= stall_r;
        end
    end

    assign words_o = words_r;
    assign stall_o = stall_r;
`endif

    assign rd_en_o   = rd_en_s;
    assign m_valid_o = valid_s;
    assign m_last_o  = valid_s && (fidx_r == FIDX_W'(FRAME_LEN - 1));
    assign busy_o    = (state_r != IDLE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed plus randomized bench for fifo_stream_reader against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int DW = 16;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rd_rst_i;
    logic          en_i;
    logic          rd_en_o;
    logic [DW-1:0] rd_data_i;
    logic          empty_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic          busy_o;
`ifdef FIFO_READER_STATS_EN
    logic [31:0]   words_o;
    logic [31:0]   stall_o;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .rd_clk_i  (clk),
        .rd_rst_i  (rd_rst_i),
        .en_i      (en_i),
        .rd_en_o   (rd_en_o),
        .rd_data_i (rd_data_i),
        .empty_i   (empty_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .busy_o    (busy_o)
`ifdef FIFO_READER_STATS_EN
        ,
        .words_o   (words_o),
        .stall_o   (stall_o)
`endif
    );

    int total = 0;
    int failed = 0;
    int cyc = 0;
    int outstanding = 0;
    int npop = 0;
    int mwords = 0;
    int mstalls = 0;
    int first_rd = -1;
    int first_valid = -1;
    int last_pop_cyc = -1;
    logic hold_empty = 1'b0;
    logic hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock: apply inputs at the falling edge, check the model, then advance.
    task automatic tick(input logic en, input logic rdy);
        logic pop;
        logic acc;
        logic [DW-1:0] e;
        en_i      = en;
        m_ready_i = rdy;
        empty_i   = (fifo_q.size() == 0) || hold_empty;
        #1;
        pop = m_valid_o && m_ready_i;
        acc = rd_en_o && !empty_i;
        if (!rd_rst_i) begin
            if (empty_i) check("rd_en_while_empty", 32'(rd_en_o), 32'd0);
            if (hold_v && m_valid_o) check("head_stable", 32'(m_data_o), 32'(hold_d));
            if (first_rd < 0 && rd_en_o) first_rd = cyc;
            if (first_valid < 0 && m_valid_o) first_valid = cyc;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(m_data_o), 32'(e));
                    check("last", 32'(m_last_o), 32'((npop % FL) == FL - 1));
                end
                npop++;
                mwords++;
                last_pop_cyc = cyc;
            end
            if (m_valid_o && !m_ready_i) mstalls++;
            outstanding += int'(acc) - int'(pop);
            check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
            hold_v = m_valid_o && !m_ready_i;
            hold_d = m_data_o;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (acc) rd_data_i = fifo_q.pop_front();
    endtask

    task automatic do_reset();
        rd_rst_i = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rd_rst_i    = 1'b0;
        outstanding = 0;
        npop        = 0;
        mwords      = 0;
        mstalls     = 0;
        hold_v      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 20) begin
            tick(1'b0, 1'b1);
            n++;
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rd_rst_i  = 1'b1;
        en_i      = 1'b0;
        m_ready_i = 1'b0;
        rd_data_i = '0;
        empty_i   = 1'b1;
        @(negedge clk);

        // Reset with five words waiting and enable low.
        for (int i = 0; i < 5; i++) load(DW'(16'h00A0 + i));
        do_reset();
        empty_i = 1'b0;
        #1;
        check("rst_rd_en", 32'(rd_en_o), 32'd0);
        check("rst_valid", 32'(m_valid_o), 32'd0);
        check("rst_data", 32'(m_data_o), 32'd0);
        check("rst_last", 32'(m_last_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        check("idle_no_read", 32'(rd_en_o), 32'd0);
        fifo_q.delete();
        exp_q.delete();

        // Sixteen words at full rate; two frames.
        for (int i = 1; i <= 16; i++) load(DW'(i));
        first_rd = -1;
        first_valid = -1;
        for (int n = 0; n < 40 && npop < 16; n++) tick(1'b1, 1'b1);
        check("stream16_count", 32'(npop), 32'd16);
        check("first_latency", 32'(first_valid - first_rd), 32'd2);
        check("no_bubbles", 32'(last_pop_cyc - first_valid), 32'd15);
        wait_idle("idle_after_16");

        // Backpressure: two words held, reads stopped, then resume.
        for (int i = 0; i < 20; i++) load(DW'(16'h0100 + i));
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        #1;
        check("bp_outstanding", 32'(outstanding), 32'd2);
        check("bp_rd_en_low", 32'(rd_en_o), 32'd0);
        check("bp_valid", 32'(m_valid_o), 32'd1);
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) tick(1'b1, 1'b1);
        check("bp_all_delivered", 32'(exp_q.size()), 32'd0);
        wait_idle("idle_after_bp");

        // Enable drops right after a read: the in-flight word is still delivered.
        for (int i = 0; i < 6; i++) load(DW'(16'h0200 + i));
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        #1;
        check("drain_state", 32'(dut.state_r == DRAIN), 32'd1);
        check("drain_busy", 32'(busy_o), 32'd1);
        wait_idle("drain_to_idle");
        check("drain_outstanding", 32'(outstanding), 32'd0);
        check("drain_delivered", 32'(exp_q.size()), 32'(fifo_q.size()));

        // Random backpressure, empty flag and enable gaps.
        for (int i = 0; i < 40; i++) load(DW'($urandom));
        for (int n = 0; n < 400; n++) begin
            hold_empty = ($urandom_range(0, 2) == 0);
            tick(($urandom_range(0, 7) != 0), 1'($urandom));
        end
        hold_empty = 1'b0;
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) tick(1'b1, 1'b1);
        wait_idle("idle_after_rand");
        check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
        check("rand_fifo_empty", 32'(fifo_q.size()), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("stats_words", words_o, 32'(mwords));
        check("stats_stall", stall_o, 32'(mstalls));
`endif

        // Reset while the buffer holds two words.
        for (int i = 0; i < 4; i++) load(DW'(16'h0300 + i));
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        #1;
        check("pre_rst_outstanding", 32'(outstanding), 32'd2);
        check("pre_rst_valid", 32'(m_valid_o), 32'd1);
        fifo_q.delete();
        exp_q.delete();
        do_reset();
        #1;
        check("post_rst_valid", 32'(m_valid_o), 32'd0);
        check("post_rst_fidx", 32'(dut.fidx_r), 32'd0);
        check("post_rst_last", 32'(m_last_o), 32'd0);
        check("post_rst_busy", 32'(busy_o), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("post_rst_words", words_o, 32'd0);
        check("post_rst_stall", stall_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
